// File: rtl/uart_program_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_program_loader_pkg
// Shared types and constants for the UART program loader.
//   - loader_state_e : frame-parsing states of the loader FSM
//   - rx_state_e     : bit-level states of the UART receiver
//   - SYNC_BYTE      : frame start marker
//   - sum8()         : 8-bit wrapping add used for the frame checksum
//   - len_in_range() : word-count acceptance test for the LEN field
// Optional feature macro: LOADER_CHECKSUM_EN (adds the ST_CSUM state).
// -----------------------------------------------------------------------------
package uart_program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_CSUM    = 3'd7
`endif
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // 8-bit wrapping sum; the carry is intentionally discarded
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    // A frame must carry at least one word and must fit in the RAM
    function automatic logic len_in_range(input logic [15:0] len, input logic [31:0] max_words);
        return (len != 16'd0) && ({16'd0, len} <= max_words);
    endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// -----------------------------------------------------------------------------
// uart_program_loader_if
// Write port toward the instruction RAM.
//   mem_we    : one-cycle write strobe
//   mem_addr  : word address (ADDR_W bits)
//   mem_wdata : 16-bit instruction word
// master = loader (drives), slave = RAM (receives).
// -----------------------------------------------------------------------------
interface uart_program_loader_if #(
    parameter int ADDR_W = 12
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_program_loader_uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with a 2-flop input synchronizer.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   rx_i         : raw RX line (idle high, asynchronous to clk)
//   byte_o       : last good byte, LSB received first
//   byte_valid_o : one-cycle pulse per byte with a good stop bit
//   frame_err_o  : one-cycle pulse when the stop bit is sampled low
// A falling edge starts reception; the start bit is re-checked at mid-bit and a
// glitch returns to idle. All later samples are taken at bit centres.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_program_loader_pkg::*;
#(
    parameter int CLK_HZ = 25_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    rx_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        sync1_q, sync2_q, prev_q;

    // Synchronizer chain plus one-cycle-delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: bit timing and sampling
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    // A line back high at mid-start-bit was noise
                    if (!sync2_q) begin
                        state_d = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (sync2_q) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// -----------------------------------------------------------------------------
// uart_program_loader
// Receives a program image over UART and writes it into instruction RAM while
// holding the CPU in reset. Frame: A5 LEN_HI LEN_LO {W_HI W_LO} x LEN [CSUM].
//   clk, rst_n : system clock, asynchronous active-low reset
//   uart_rx_i  : raw UART RX line
//   mem        : RAM write port (mem_we, mem_addr, mem_wdata), master side
//   cpu_hold   : reset request to the CPU (set during load, kept after abort)
//   busy       : frame in progress
//   done       : sticky, last frame loaded OK
//   error      : sticky, last frame aborted
// Optional feature macro: LOADER_CHECKSUM_EN -- when defined a trailing 8-bit
// checksum byte (wrapping sum of LEN and data bytes) must match for DONE.
// -----------------------------------------------------------------------------
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLK_HZ         = 25_000_000,
    parameter int BAUD           = 115_200,
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_rx_i,
    uart_program_loader_if.master mem,
    output logic cpu_hold,
    output logic busy,
    output logic done,
    output logic error
);

    localparam int          WL_W      = ADDR_W + 1;
    localparam int          TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    logic [7:0] rx_byte_s;
    logic       rx_valid_s;
    logic       rx_ferr_s;

    loader_state_e     state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [WL_W-1:0]   words_left_q, words_left_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_hi_q, data_hi_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic [15:0] len_s;
    logic        in_frame_s;
    logic        timeout_s;
    logic        enter_done_s;
    logic        enter_error_s;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (uart_rx_i),
        .byte_o       (rx_byte_s),
        .byte_valid_o (rx_valid_s),
        .frame_err_o  (rx_ferr_s)
    );

    assign len_s      = {len_hi_q, rx_byte_s};
    assign in_frame_s = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign timeout_s  = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Loader state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_hi_q     <= 8'h00;
            words_left_q <= '0;
            addr_q       <= '0;
            data_hi_q    <= 8'h00;
            to_cnt_q     <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 16'h0000;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
            data_hi_q    <= data_hi_d;
            to_cnt_q     <= to_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    // Frame parser: next state, RAM write, status flags, inter-byte timeout
    always_comb begin
        state_d       = state_q;
        len_hi_d      = len_hi_q;
        words_left_d  = words_left_q;
        addr_d        = addr_q;
        data_hi_d     = data_hi_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        cpu_hold_d    = cpu_hold_q;
        busy_d        = busy_q;
        done_d        = done_q;
        error_d       = error_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        enter_done_s  = 1'b0;
        enter_error_s = 1'b0;

        // Idle gap counter only runs inside a frame and restarts on each byte
        if (rx_valid_s || !in_frame_s) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (rx_valid_s && (rx_byte_s == SYNC_BYTE)) begin
                    state_d    = ST_LEN_HI;
                    busy_d     = 1'b1;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    addr_d     = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 8'h00;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid_s) begin
                    len_hi_d = rx_byte_s;
                    state_d  = ST_LEN_LO;
`ifdef LOADER_CHECKSUM_EN
                    sum_d    = sum8(sum_q, rx_byte_s);
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN_LO: begin
                if (rx_valid_s) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum8(sum_q, rx_byte_s);
`endif
                    if (len_in_range(len_s, MAX_WORDS)) begin
                        words_left_d = len_s[WL_W-1:0];
                        state_d      = ST_DATA_HI;
                    end else begin
                        enter_error_s = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA_HI: begin
                if (rx_valid_s) begin
                    data_hi_d = rx_byte_s;
                    state_d   = ST_DATA_LO;
`ifdef LOADER_CHECKSUM_EN
                    sum_d     = sum8(sum_q, rx_byte_s);
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA_LO: begin
                if (rx_valid_s) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = addr_q;
                    mem_wdata_d  = {data_hi_q, rx_byte_s};
                    addr_d       = addr_q + ADDR_W'(1);
                    words_left_d = words_left_q - WL_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    sum_d        = sum8(sum_q, rx_byte_s);
`endif
                    if (words_left_q == WL_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        enter_done_s = 1'b1;
`endif
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_valid_s) begin
                    if (rx_byte_s == sum_q) begin
                        enter_done_s = 1'b1;
                    end else begin
                        enter_error_s = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line faults abort a frame in progress; outside a frame they are ignored
        if (in_frame_s && !rx_valid_s && (rx_ferr_s || timeout_s)) begin
            enter_error_s = 1'b1;
        end else begin
            enter_error_s = enter_error_s;
        end

        // DONE releases the CPU; ERROR keeps it held
        if (enter_done_s) begin
            state_d    = ST_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            error_d    = 1'b0;
            cpu_hold_d = 1'b0;
        end else if (enter_error_s) begin
            state_d    = ST_ERROR;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
        end else begin
            busy_d = busy_d;
        end
    end

    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_program_loader
// Self-checking bench: a table of hand-derived frames, randomized frames
// checked against a frame-level model, and hand sequences for timeout and
// mid-frame reset. Runs with 10 clocks per UART bit and a 500-clock timeout.
// Optional feature macro: LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_uart_program_loader;

    localparam int CLK_HZ  = 1_000_000;
    localparam int BAUD    = 100_000;
    localparam int ADDR_W  = 12;
    localparam int TMO     = 500;
    localparam int CPB     = CLK_HZ / BAUD;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic cpu_hold, busy, done, error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_program_loader_if #(.ADDR_W(ADDR_W)) mem_if ();

    uart_program_loader #(
        .CLK_HZ         (CLK_HZ),
        .BAUD           (BAUD),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx_i (rx),
        .mem       (mem_if.master),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // Captured RAM writes as {addr, data}
    logic [27:0] wr_q[$];

    always @(negedge clk) begin
        if (mem_if.mem_we) wr_q.push_back({mem_if.mem_addr, mem_if.mem_wdata});
    end

    typedef struct {
        logic [63:0] bytes;   // first byte in the top octet
        int          n;
        int          bad_idx; // byte whose stop bit is forced low, -1 for none
        logic        exp_done;
        logic        exp_err;
        logic        exp_hold;
        int          exp_wr;
        logic [11:0] exp_addr; // last write
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_vec(input logic [63:0] bytes, input int n, input int bad_idx);
        for (int i = 0; i < n; i++) send_byte(bytes[63 - 8*i -: 8], (i != bad_idx));
    endtask

    task automatic send_q(input logic [7:0] fb[$]);
        foreach (fb[i]) send_byte(fb[i], 1'b1);
    endtask

    initial begin
        int          nf;
        logic [7:0]  fb[$];
        logic [27:0] exp_wr[$];
        logic [7:0]  sum;
        logic [7:0]  junk;
        int          len;
        logic        bad_csum;
        logic        exp_ok;
        logic [15:0] w;
        string       nm;

        nf = CSUM_EN ? 8 : 7;
        //           bytes                       n                 bad  done      err      hold     wr addr    data
        vecs[0]  = '{64'h3C00_0000_0000_0000, 1,                 -1, 1'b0,    1'b0,    1'b0,    0, 12'h000, 16'h0000};
        vecs[1]  = '{64'hA500_0212_34AB_CDC0, nf,                -1, 1'b1,    1'b0,    1'b0,    2, 12'h001, 16'hABCD};
        vecs[2]  = '{64'hA500_0212_34AB_CDC1, 8,                 -1, !CSUM_EN, CSUM_EN, CSUM_EN, 2, 12'h001, 16'hABCD};
        vecs[3]  = '{64'hA500_0212_34AB_CDC0, nf,                -1, 1'b1,    1'b0,    1'b0,    2, 12'h001, 16'hABCD};
        vecs[4]  = '{64'hA500_0000_0000_0000, 3,                 -1, 1'b0,    1'b1,    1'b1,    0, 12'h000, 16'h0000};
        vecs[5]  = '{64'hA500_0212_34AB_CDC0, nf,                -1, 1'b1,    1'b0,    1'b0,    2, 12'h001, 16'hABCD};
        vecs[6]  = '{64'hA510_0100_0000_0000, 3,                 -1, 1'b0,    1'b1,    1'b1,    0, 12'h000, 16'h0000};
        vecs[7]  = '{64'hA500_0212_34AB_CDC0, nf,                -1, 1'b1,    1'b0,    1'b0,    2, 12'h001, 16'hABCD};
        vecs[8]  = '{64'hA500_0212_0000_0000, 4,                  2, 1'b0,    1'b1,    1'b1,    0, 12'h000, 16'h0000};
        vecs[9]  = '{64'hA500_01BE_EFAE_0000, CSUM_EN ? 6 : 5,   -1, 1'b1,    1'b0,    1'b0,    1, 12'h000, 16'hBEEF};
        vecs[10] = '{64'hA500_01A5_A54B_0000, CSUM_EN ? 6 : 5,   -1, 1'b1,    1'b0,    1'b0,    1, 12'h000, 16'hA5A5};
        vecs[11] = '{64'h0000_0000_0000_0000, 1,                 -1, 1'b1,    1'b0,    1'b0,    0, 12'h000, 16'h0000};

        // Reset, then a long idle line
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        check("reset_done",  {31'd0, done},     32'd0);
        check("reset_error", {31'd0, error},    32'd0);
        check("reset_hold",  {31'd0, cpu_hold}, 32'd0);
        check("reset_busy",  {31'd0, busy},     32'd0);
        check("reset_addr",  {20'd0, mem_if.mem_addr}, 32'd0);
        check("reset_wdata", {16'd0, mem_if.mem_wdata}, 32'd0);

        // Table of hand-derived frames
        for (int i = 0; i < 12; i++) begin
            wr_q.delete();
            send_vec(vecs[i].bytes, vecs[i].n, vecs[i].bad_idx);
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_done", i),  {31'd0, done},     {31'd0, vecs[i].exp_done});
            check($sformatf("vec%0d_error", i), {31'd0, error},    {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_hold", i),  {31'd0, cpu_hold}, {31'd0, vecs[i].exp_hold});
            check($sformatf("vec%0d_busy", i),  {31'd0, busy},     32'd0);
            check($sformatf("vec%0d_nwr", i),   wr_q.size(),       vecs[i].exp_wr);
            if (vecs[i].exp_wr > 0 && wr_q.size() > 0)
                check($sformatf("vec%0d_lastwr", i), {4'd0, wr_q[$]},
                      {4'd0, vecs[i].exp_addr, vecs[i].exp_data});
        end

        // Randomized frames against a frame-level model
        for (int t = 0; t < 20; t++) begin
            fb.delete();
            exp_wr.delete();
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h5A;
            fb.push_back(junk);              // ignored outside a frame
            fb.push_back(8'hA5);
            len = $urandom_range(0, 4);
            fb.push_back(8'h00);
            fb.push_back(8'(len));
            sum = 8'(len);
            for (int k = 0; k < len; k++) begin
                w = 16'($urandom);
                fb.push_back(w[15:8]);
                fb.push_back(w[7:0]);
                sum = sum + w[15:8] + w[7:0];
                exp_wr.push_back({12'(k), w});
            end
            bad_csum = CSUM_EN && ($urandom_range(0, 3) == 0);
            if (CSUM_EN && len > 0) fb.push_back(bad_csum ? ~sum : sum);
            exp_ok = (len > 0) && !bad_csum;

            wr_q.delete();
            send_q(fb);
            repeat (20) @(negedge clk);
            nm = $sformatf("rnd%0d_len%0d", t, len);
            check({nm, "_done"},  {31'd0, done},     {31'd0, exp_ok});
            check({nm, "_error"}, {31'd0, error},    {31'd0, !exp_ok});
            check({nm, "_hold"},  {31'd0, cpu_hold}, {31'd0, !exp_ok});
            check({nm, "_nwr"},   wr_q.size(),       exp_wr.size());
            for (int k = 0; k < exp_wr.size() && k < wr_q.size(); k++)
                check($sformatf("%s_wr%0d", nm, k), {4'd0, wr_q[k]}, {4'd0, exp_wr[k]});
        end

        // Inter-byte timeout after a partial frame
        wr_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (390) @(negedge clk);
        check("tmo_before_error", {31'd0, error}, 32'd0);
        check("tmo_before_busy",  {31'd0, busy},  32'd1);
        repeat (150) @(negedge clk);
        check("tmo_after_error", {31'd0, error},    32'd1);
        check("tmo_after_hold",  {31'd0, cpu_hold}, 32'd1);
        check("tmo_after_busy",  {31'd0, busy},     32'd0);
        check("tmo_nwr",         wr_q.size(),       32'd0);

        // Asynchronous reset during DATA_HI of the second word
        wr_q.delete();
        send_vec(64'hA500_0212_3400_0000, 5, -1);
        check("mid_busy", {31'd0, busy},     32'd1);
        check("mid_hold", {31'd0, cpu_hold}, 32'd1);
        check("mid_nwr",  wr_q.size(),       32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",  {31'd0, busy},     32'd0);
        check("arst_hold",  {31'd0, cpu_hold}, 32'd0);
        check("arst_done",  {31'd0, done},     32'd0);
        check("arst_error", {31'd0, error},    32'd0);
        check("arst_we",    {31'd0, mem_if.mem_we}, 32'd0);
        check("arst_addr",  {20'd0, mem_if.mem_addr}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        wr_q.delete();
        send_vec(64'hA500_0212_34AB_CDC0, nf, -1);
        repeat (20) @(negedge clk);
        check("post_rst_done", {31'd0, done}, 32'd1);
        check("post_rst_nwr",  wr_q.size(),   32'd2);
        if (wr_q.size() == 2) begin
            check("post_rst_wr0", {4'd0, wr_q[0]}, {4'd0, 12'h000, 16'h1234});
            check("post_rst_wr1", {4'd0, wr_q[1]}, {4'd0, 12'h001, 16'hABCD});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
